// File: rtl/cusp_pkg.sv
// Shared definitions for the cusp pulse shaper: default widths and filter
// constants, the two-state FSM encoding and the output saturation helper.
package cusp_pkg;

    localparam int ADC_W_DEF     = 12;
    localparam int ACC_W_DEF     = 32;
    localparam int OUT_W_DEF     = 16;
    localparam int K_DEF         = 11;
    localparam int L_DEF         = 5;
    localparam int M1_DEF        = 16;
    localparam int M2_DEF        = 1;
    localparam int OUT_SHIFT_DEF = 4;

    // Working width for the saturation compare; holds any ACC_W up to 64.
    localparam int SAT_W = 64;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } cusp_state_t;

    typedef struct packed {
        logic clamp_hi;
        logic clamp_lo;
    } sat_t;

    // Decide whether a sign-extended value fits a signed out_w-bit field,
    // reporting which rail it must be clamped to when it does not.
    function automatic sat_t saturate(input logic signed [SAT_W-1:0] t,
                                      input int                      out_w);
        logic signed [SAT_W-1:0] one_v;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_t                    r;
        one_v      = SAT_W'(1'b1);
        max_v      = (one_v <<< (out_w - 1)) - one_v;
        min_v      = ~max_v;
        r.clamp_hi = (t > max_v);
        r.clamp_lo = (t < min_v);
        return r;
    endfunction

endpackage

// File: rtl/cusp_shaper_param_if.sv
// Sample-in / filtered-sample-out bundle of the cusp shaper.
interface cusp_shaper_param_if
    import cusp_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic                    in_valid;
    logic [ADC_W-1:0]        input_data;
    logic                    out_valid;
    logic signed [OUT_W-1:0] output_data;
    logic                    primed;
    logic                    ovf;

    modport master (
        output in_valid, input_data,
        input  out_valid, output_data, primed, ovf
    );

    modport slave (
        input  in_valid, input_data,
        output out_valid, output_data, primed, ovf
    );
endinterface

// File: rtl/cusp_delay_line.sv
// Enable-gated shift register; dout is the entry written DEPTH shifts ago.
module cusp_delay_line #(
    parameter int DEPTH = 11,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [DEPTH-1:0][WIDTH-1:0] line_q;
    logic [DEPTH-1:0][WIDTH-1:0] line_d;

    // Next contents: flush on clear, shift on enable, otherwise hold.
    always_comb begin
        line_d = line_q;
        if (clr) begin
            line_d = '0;
        end else if (en) begin
            line_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                line_d[i] = line_q[i-1];
            end
        end else begin
            line_d = line_q;
        end
    end

    // Storage for the delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign dout = line_q[DEPTH-1];
endmodule

// File: rtl/cusp_shaper_param.sv
// Parametrised cusp-like pulse shaper: delay/difference stage, p integrator,
// q/s integrators, then scaled and saturated output register.
module cusp_shaper_param
    import cusp_pkg::*;
#(
    parameter int ADC_W     = ADC_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int K         = K_DEF,
    parameter int L         = L_DEF,
    parameter int M1        = M1_DEF,
    parameter int M2        = M2_DEF,
    parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
    input logic                clk,
    input logic                reset,
    input logic                clear,
    cusp_shaper_param_if.slave bus
);
    localparam int                      CNT_W      = $clog2(K + L + 2);
    localparam logic [CNT_W-1:0]        PRIME_LAST = CNT_W'(K + L);
    localparam logic signed [ACC_W-1:0] K_C        = ACC_W'(K);
    localparam logic signed [ACC_W-1:0] M1_C       = ACC_W'(M1);
    localparam logic signed [ACC_W-1:0] M2_C       = ACC_W'(M2);
    localparam logic signed [OUT_W-1:0] OUT_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN    = {1'b1, {(OUT_W-1){1'b0}}};

    logic                    accept_s;
    logic [ADC_W-1:0]        v_old_s;
    logic signed [ACC_W-1:0] dl_old_s;
    logic signed [ACC_W-1:0] q_new_s;
    logic signed [ACC_W-1:0] t_s;
    logic signed [SAT_W-1:0] t_ext_s;
    sat_t                    sat_s;

    cusp_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    primed_q, primed_d;
    logic [ADC_W-1:0]        prev_q, prev_d;
    logic signed [ACC_W-1:0] dk_q, dk_d, dl_q, dl_d;
    logic signed [ACC_W-1:0] p_q, p_d, q_q, q_d, s_q, s_d;
    logic                    s1_vld_q, s1_vld_d, s1_run_q, s1_run_d;
    logic                    s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic                    out_vld_q, out_vld_d, ovf_q, ovf_d;
    logic signed [OUT_W-1:0] out_q, out_d;

    // A restart in the same cycle wins over an incoming sample.
    assign accept_s = bus.in_valid & ~clear;

    cusp_delay_line #(.DEPTH(K), .WIDTH(ADC_W)) u_sample_line (
        .clk (clk), .rst_n(reset), .clr(clear), .en(accept_s),
        .din (bus.input_data), .dout(v_old_s)
    );

    // dl values enter the history as they leave stage 1, so the tail is dl(n-L).
    cusp_delay_line #(.DEPTH(L), .WIDTH(ACC_W)) u_dl_line (
        .clk (clk), .rst_n(reset), .clr(clear), .en(s1_vld_q),
        .din (dl_q), .dout(dl_old_s)
    );

    // Priming FSM next state: count accepted samples until the history is full.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = PRIME;
            cnt_d   = '0;
        end else if (accept_s && (state_q == PRIME)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
            if (cnt_q == PRIME_LAST) begin
                state_d = RUN;
            end else begin
                state_d = PRIME;
            end
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
        primed_d = (state_d == RUN);
    end

    // Priming FSM registers with registered primed flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= PRIME;
            cnt_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
        end
    end

    // Stage 1: difference terms; tag samples that complete the priming window.
    always_comb begin
        prev_d   = prev_q;
        dk_d     = dk_q;
        dl_d     = dl_q;
        s1_vld_d = 1'b0;
        s1_run_d = 1'b0;
        if (clear) begin
            prev_d = '0;
            dk_d   = '0;
            dl_d   = '0;
        end else if (accept_s) begin
            prev_d   = bus.input_data;
            dk_d     = ACC_W'(bus.input_data) - ACC_W'(v_old_s);
            dl_d     = ACC_W'(bus.input_data) - ACC_W'(prev_q);
            s1_vld_d = 1'b1;
            s1_run_d = (state_q == RUN) || (cnt_q == PRIME_LAST);
        end else begin
            s1_vld_d = 1'b0;
            s1_run_d = 1'b0;
        end
    end

    // Stages 2 and 3: p integrator, then q and s (s uses the freshly updated q).
    always_comb begin
        q_new_s  = q_q + M2_C * p_q;
        p_d      = p_q;
        q_d      = q_q;
        s_d      = s_q;
        s2_vld_d = 1'b0;
        s3_vld_d = 1'b0;
        if (clear) begin
            p_d = '0;
            q_d = '0;
            s_d = '0;
        end else begin
            if (s1_vld_q && s1_run_q) begin
                p_d      = p_q + dk_q - K_C * dl_old_s;
                s2_vld_d = 1'b1;
            end else begin
                s2_vld_d = 1'b0;
            end
            if (s2_vld_q) begin
                q_d      = q_new_s;
                s_d      = s_q + q_new_s + M1_C * p_q;
                s3_vld_d = 1'b1;
            end else begin
                s3_vld_d = 1'b0;
            end
        end
    end

    // Stage 4: scale, clamp to the output range and record any clamping.
    always_comb begin
        t_s       = s_q >>> OUT_SHIFT;
        t_ext_s   = SAT_W'(t_s);
        sat_s     = saturate(t_ext_s, OUT_W);
        out_d     = out_q;
        ovf_d     = ovf_q;
        out_vld_d = 1'b0;
        if (clear) begin
            out_d = '0;
            ovf_d = 1'b0;
        end else if (s3_vld_q) begin
            out_vld_d = 1'b1;
            ovf_d     = ovf_q | sat_s.clamp_hi | sat_s.clamp_lo;
            if (sat_s.clamp_hi) begin
                out_d = OUT_MAX;
            end else if (sat_s.clamp_lo) begin
                out_d = OUT_MIN;
            end else begin
                out_d = t_s[OUT_W-1:0];
            end
        end else begin
            out_vld_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q    <= '0;
            dk_q      <= '0;
            dl_q      <= '0;
            s1_vld_q  <= 1'b0;
            s1_run_q  <= 1'b0;
            p_q       <= '0;
            s2_vld_q  <= 1'b0;
            q_q       <= '0;
            s_q       <= '0;
            s3_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            dk_q      <= dk_d;
            dl_q      <= dl_d;
            s1_vld_q  <= s1_vld_d;
            s1_run_q  <= s1_run_d;
            p_q       <= p_d;
            s2_vld_q  <= s2_vld_d;
            q_q       <= q_d;
            s_q       <= s_d;
            s3_vld_q  <= s3_vld_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.out_valid   = out_vld_q;
    assign bus.output_data = out_q;
    assign bus.primed      = primed_q;
    assign bus.ovf         = ovf_q;
endmodule
